// File: rtl/mux_scan_reg.sv
// Registered N-channel mux with manual select, auto-scan and valid/ready output.
// Optional O_par output enabled by defining MUX_SCAN_PARITY_EN.
module mux_scan_reg #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] I,
    input  logic [SEL_W-1:0]          S,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       mask,
    input  logic                      O_ready,
    output logic [WIDTH-1:0]          O,
    output logic                      O_valid,
    output logic [SEL_W-1:0]          O_ch
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic                      O_par
`endif
);

    localparam int CNT_W = $clog2(DWELL + 1);

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t           st, nx_st;
    logic [SEL_W-1:0] ptr, nx_ptr;
    logic [CNT_W-1:0] cnt, nx_cnt;
    logic [WIDTH-1:0] nx_o;
    logic             nx_valid;
    logic [SEL_W-1:0] nx_ch;
    logic [SEL_W-1:0] sel;
    logic             take;
    logic [SEL_W-1:0] low_ch;
    logic [SEL_W-1:0] nxt_ch;
    logic             load;

    logic [WIDTH-1:0] chan [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign chan[k] = I[k*WIDTH +: WIDTH];
    end

    assign load = !O_valid || O_ready;

    // Descending loops so the lowest index / smallest offset wins.
    always_comb begin
        low_ch = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (mask[k]) low_ch = SEL_W'(k);
        end
    end

    // Offset CHANNELS wraps to ptr itself: sole enabled channel repeats.
    always_comb begin
        nxt_ch = ptr;
        for (int k = CHANNELS; k >= 1; k--) begin
            if (mask[ptr + SEL_W'(k)]) nxt_ch = ptr + SEL_W'(k);
        end
    end

    always_comb begin
        nx_st    = st;
        nx_ptr   = ptr;
        nx_cnt   = cnt;
        nx_valid = O_valid;
        nx_ch    = O_ch;
        sel      = O_ch;
        take     = 1'b0;
        if (load) begin
            if (!mode) begin
                nx_st = MANUAL;
                sel   = S;
                take  = 1'b1;
            end else if (st != SCAN) begin
                nx_st = SCAN;
                if (mask != '0) begin
                    sel    = low_ch;
                    take   = 1'b1;
                    nx_ptr = low_ch;
                    nx_cnt = CNT_W'(1);
                end else begin
                    nx_valid = 1'b0;
                    nx_ptr   = '0;
                    nx_cnt   = '0;
                end
            end else if (mask == '0) begin
                nx_valid = 1'b0;
                nx_cnt   = '0;
            end else if (mask[ptr] && cnt != '0 && cnt < CNT_W'(DWELL)) begin
                sel    = ptr;
                take   = 1'b1;
                nx_cnt = cnt + CNT_W'(1);
            end else begin
                sel    = nxt_ch;
                take   = 1'b1;
                nx_ptr = nxt_ch;
                nx_cnt = CNT_W'(1);
            end
        end
        if (take) begin
            nx_valid = 1'b1;
            nx_ch    = sel;
        end
        nx_o = take ? chan[sel] : O;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            O       <= '0;
            O_valid <= 1'b0;
            O_ch    <= '0;
        end else begin
            st      <= nx_st;
            ptr     <= nx_ptr;
            cnt     <= nx_cnt;
            O       <= nx_o;
            O_valid <= nx_valid;
            O_ch    <= nx_ch;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            O_par <= 1'b0;
        end else if (take) begin
            O_par <= ^chan[sel];
        end
    end
`endif

endmodule

// File: tb/tb_mux_scan_reg.sv
// Directed self-checking bench for mux_scan_reg (WIDTH=8, CHANNELS=4, DWELL=2).
module tb_mux_scan_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] I;
    logic [1:0]  S;
    logic        mode;
    logic [3:0]  mask;
    logic        O_ready;
    logic [7:0]  O;
    logic        O_valid;
    logic [1:0]  O_ch;
`ifdef MUX_SCAN_PARITY_EN
    logic        O_par;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_scan_reg #(
        .WIDTH(8),
        .CHANNELS(4),
        .DWELL(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .I(I),
        .S(S),
        .mode(mode),
        .mask(mask),
        .O_ready(O_ready),
        .O(O),
        .O_valid(O_valid),
        .O_ch(O_ch)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .O_par(O_par)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] eo,
                       input logic ev, input logic [1:0] ec);
        checks++;
        assert (O_valid === ev) else begin
            errors++;
            $error("FAIL %s valid: got %b expected %b", tag, O_valid, ev);
        end
        checks++;
        assert (O === eo) else begin
            errors++;
            $error("FAIL %s O: got %h expected %h", tag, O, eo);
        end
        checks++;
        assert (O_ch === ec) else begin
            errors++;
            $error("FAIL %s O_ch: got %0d expected %0d", tag, O_ch, ec);
        end
    endtask

    initial begin
        rst = 1'b1;
        I = 32'h44332211;
        S = 2'd0;
        mode = 1'b0;
        mask = 4'b0000;
        O_ready = 1'b1;
        step();
        step();
        chk("reset", 8'h00, 1'b0, 2'd0);

        // manual select
        rst = 1'b0;
        S = 2'd0; step(); chk("man0", 8'h11, 1'b1, 2'd0);
        S = 2'd1; step(); chk("man1", 8'h22, 1'b1, 2'd1);
        S = 2'd2; step(); chk("man2", 8'h33, 1'b1, 2'd2);
        S = 2'd3; step(); chk("man3", 8'h44, 1'b1, 2'd3);

        // scan with mask 1011, dwell 2
        mode = 1'b1;
        mask = 4'b1011;
        step(); chk("scan_a", 8'h11, 1'b1, 2'd0);
        step(); chk("scan_b", 8'h11, 1'b1, 2'd0);
        step(); chk("scan_c", 8'h22, 1'b1, 2'd1);
        step(); chk("scan_d", 8'h22, 1'b1, 2'd1);
        step(); chk("scan_e", 8'h44, 1'b1, 2'd3);
        step(); chk("scan_f", 8'h44, 1'b1, 2'd3);
        step(); chk("scan_g", 8'h11, 1'b1, 2'd0);
        step(); chk("scan_h", 8'h11, 1'b1, 2'd0);

        // stall in the middle of channel 1 dwell
        step(); chk("pre_stall", 8'h22, 1'b1, 2'd1);
        O_ready = 1'b0;
        I = 32'hd4c3b2a1;
        S = 2'd3;
        step(); chk("stall1", 8'h22, 1'b1, 2'd1);
        I = 32'h01020304;
        step(); chk("stall2", 8'h22, 1'b1, 2'd1);
        I = 32'hd4c3b2a1;
        step(); chk("stall3", 8'h22, 1'b1, 2'd1);
        O_ready = 1'b1;
        step(); chk("resume1", 8'hb2, 1'b1, 2'd1);
        step(); chk("resume2", 8'hd4, 1'b1, 2'd3);

        // mask edge cases
        mask = 4'b0011;
        step(); chk("clr_ptr", 8'ha1, 1'b1, 2'd0);
        step(); chk("clr_dwell", 8'ha1, 1'b1, 2'd0);
        mask = 4'b0000;
        step(); chk("mask0", 8'ha1, 1'b0, 2'd0);
        step(); chk("mask0_b", 8'ha1, 1'b0, 2'd0);
        mask = 4'b1100;
        step(); chk("restore1", 8'hc3, 1'b1, 2'd2);
        step(); chk("restore2", 8'hc3, 1'b1, 2'd2);
        step(); chk("restore3", 8'hd4, 1'b1, 2'd3);

        // reset during a stall
        O_ready = 1'b0;
        step(); chk("rst_stall", 8'hd4, 1'b1, 2'd3);
        rst = 1'b1;
        step(); chk("rst_mid", 8'h00, 1'b0, 2'd0);
        rst = 1'b0;
        step(); chk("post_rst", 8'hc3, 1'b1, 2'd2);

        // mode change requested during a stall
        mode = 1'b0;
        S = 2'd1;
        step(); chk("mode_stall", 8'hc3, 1'b1, 2'd2);
        O_ready = 1'b1;
        step(); chk("mode_apply", 8'hb2, 1'b1, 2'd1);

`ifdef MUX_SCAN_PARITY_EN
        I = 32'h00000700;
        step();
        checks++;
        assert (O_par === 1'b1) else begin
            errors++;
            $error("FAIL par07: got %b expected 1", O_par);
        end
        I = 32'h00000300;
        step();
        checks++;
        assert (O_par === 1'b0) else begin
            errors++;
            $error("FAIL par03: got %b expected 0", O_par);
        end
        I = 32'h00000700;
        step();
        rst = 1'b1;
        step();
        checks++;
        assert (O_par === 1'b0) else begin
            errors++;
            $error("FAIL par_rst: got %b expected 0", O_par);
        end
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
